// File: rtl/instruction_prefetch_queue.sv
// Instruction prefetch queue: fetches bytes from MMU port B, assembles big-endian
// 32-bit opcodes tagged with their fetch address, and buffers them for decode.
module instruction_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [31:0]              mem_addr,
  output logic                     mem_request,
  input  logic [7:0]               mem_data,
  input  logic                     mem_busy,
  input  logic                     redirect,
  input  logic [31:0]              redirect_target,
  input  logic                     consume,
  output logic [31:0]              opcode,
  output logic [31:0]              opcode_pc,
  output logic                     opcode_valid,
  output logic [$clog2(DEPTH):0]   queue_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_fetch_pc;
  logic [1:0]      r_byte_idx;
  logic [23:0]     r_word;
  logic [31:0]     r_fifo_op [DEPTH];
  logic [31:0]     r_fifo_pc [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW:0]     r_count;

  logic            w_req;
  logic            w_hold;
  logic            w_capture;
  logic            w_push;
  logic            w_pop;

  // A new word may only start when there is room for it, so pushes never overflow.
  assign w_hold    = (r_byte_idx == 2'd0) && (r_count == FULL_COUNT);
  assign w_capture = (r_state == S_WAIT) && !mem_busy;
  assign w_push    = w_capture && (r_byte_idx == 2'd3) && !redirect;
  assign w_pop     = consume && opcode_valid && !redirect;

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    unique case (r_state)
      S_IDLE:  w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        w_req = !w_hold;
        if (w_req && !mem_busy) w_state_nxt = S_WAIT;
      end
      S_WAIT:  if (!mem_busy) w_state_nxt = S_ISSUE;
      S_DRAIN: if (!mem_busy) w_state_nxt = S_ISSUE;
      default: w_state_nxt = S_IDLE;
    endcase
    // A DRAIN still waiting on the MMU keeps draining; issuing now would overlap requests.
    if (redirect) begin
      if (r_state == S_WAIT || (r_state == S_DRAIN && mem_busy))
        w_state_nxt = S_DRAIN;
      else
        w_state_nxt = S_ISSUE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_byte_idx <= '0;
      r_word     <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_fifo_op[i] <= '0;
        r_fifo_pc[i] <= '0;
      end
    end else if (redirect) begin
      r_fetch_pc <= {redirect_target[31:2], 2'b00};
      r_byte_idx <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_capture) begin
        unique case (r_byte_idx)
          2'd0: r_word[23:16] <= mem_data;
          2'd1: r_word[15:8]  <= mem_data;
          2'd2: r_word[7:0]   <= mem_data;
          default: begin
            r_fifo_op[r_wr_ptr] <= {r_word, mem_data};
            r_fifo_pc[r_wr_ptr] <= r_fetch_pc;
            r_wr_ptr            <= r_wr_ptr + 1'b1;
            r_fetch_pc          <= r_fetch_pc + 32'd4;
          end
        endcase
        r_byte_idx <= r_byte_idx + 2'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign mem_request  = w_req;
  assign mem_addr     = r_fetch_pc + {30'd0, r_byte_idx};
  assign opcode       = r_fifo_op[r_rd_ptr];
  assign opcode_pc    = r_fifo_pc[r_rd_ptr];
  assign opcode_valid = (r_count != '0);
  assign queue_count  = r_count;

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Bench for instruction_prefetch_queue: MMU byte model, scoreboard of expected
// {pc, opcode} stream, directed timing scenarios and a randomized phase.
module tb_instruction_prefetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic                   clk;
  logic                   reset;
  logic [31:0]            mem_addr;
  logic                   mem_request;
  logic [7:0]             mem_data;
  logic                   mem_busy;
  logic                   redirect;
  logic [31:0]            redirect_target;
  logic                   consume;
  logic [31:0]            opcode;
  logic [31:0]            opcode_pc;
  logic                   opcode_valid;
  logic [$clog2(DEPTH):0] queue_count;

  instruction_prefetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_addr        (mem_addr),
    .mem_request     (mem_request),
    .mem_data        (mem_data),
    .mem_busy        (mem_busy),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .consume         (consume),
    .opcode          (opcode),
    .opcode_pc       (opcode_pc),
    .opcode_valid    (opcode_valid),
    .queue_count     (queue_count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] op;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pops   = 0;
  int          busy_mode = 0;
  logic [31:0] lat_addr  = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] fbyte(input logic [31:0] a);
    return a[7:0] ^ a[31:24];
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return {fbyte(pc), fbyte(pc + 32'd1), fbyte(pc + 32'd2), fbyte(pc + 32'd3)};
  endfunction

  assign mem_data = fbyte(lat_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_exp(input logic [31:0] tgt);
    logic [31:0] pc;
    exp_q.delete();
    pc = {tgt[31:2], 2'b00};
    repeat (256) begin
      exp_q.push_back('{pc: pc, op: word_at(pc)});
      pc = pc + 32'd4;
    end
  endtask

  // MMU port B: latches the address of each accepted request, busy per mode.
  initial begin
    logic        acc;
    logic [31:0] a;
    int          bl;
    bl = 0;
    mem_busy = 1'b0;
    forever begin
      @(negedge clk);
      acc = mem_request && !mem_busy;
      a   = mem_addr;
      @(posedge clk);
      #1;
      if (acc) begin
        lat_addr = a;
        bl = 3;
      end
      case (busy_mode)
        1: mem_busy = ($urandom_range(0, 3) == 0);
        2: begin
          if (bl > 0) begin
            mem_busy = 1'b1;
            bl--;
          end else begin
            mem_busy = 1'b0;
          end
        end
        default: mem_busy = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted consume, plus invariants.
  initial begin
    logic        pr, pb, prd, prs;
    logic [31:0] pa;
    exp_t        e;
    pr = 1'b0; pb = 1'b0; prd = 1'b0; prs = 1'b1; pa = '0;
    forever begin
      @(negedge clk);
      if (pr && pb && !prd && !prs) chk("addr_stable_busy", mem_addr, pa);
      chk("valid_vs_count", 32'(opcode_valid), 32'(queue_count != 0));
      chk("count_le_depth", 32'(queue_count <= DEPTH), 32'd1);
      if (!reset && !redirect && consume && opcode_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: got pc %08h expected no entry", opcode_pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", opcode_pc, e.pc);
          chk("sb_opcode", opcode, e.op);
          n_pops++;
        end
      end
      pr = mem_request; pb = mem_busy; prd = redirect; prs = reset; pa = mem_addr;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int  n;
    logic seen_req;
    reset = 1'b1; redirect = 1'b0; redirect_target = '0; consume = 1'b0;
    fill_exp(RESET_PC);
    tick(); tick(); tick();
    chk("rst_req", 32'(mem_request), 32'd0);
    chk("rst_addr", mem_addr, RESET_PC);
    chk("rst_valid", 32'(opcode_valid), 32'd0);
    chk("rst_count", 32'(queue_count), 32'd0);
    chk("rst_opcode", opcode, 32'd0);
    chk("rst_opcode_pc", opcode_pc, 32'd0);
    reset = 1'b0;

    // Zero-wait: requests in odd cycles 1..7, opcode_valid first high in cycle 9.
    for (int k = 0; k <= 9; k++) begin
      chk("first_valid_cycle", 32'(opcode_valid), 32'(k == 9));
      if (k <= 8) chk("req_pattern", 32'(mem_request), 32'((k % 2 == 1) && (k <= 7)));
      if (k < 9) tick();
    end
    chk("first_opcode", opcode, 32'h0001_0203);
    chk("first_opcode_pc", opcode_pc, 32'h0);

    // Never consume: fills to DEPTH and stops requesting.
    n = 0;
    while (queue_count != DEPTH && n < 100) begin tick(); n++; end
    chk("fill_count", 32'(queue_count), DEPTH);
    repeat (20) begin
      tick();
      chk("full_no_req", 32'(mem_request), 32'd0);
      chk("full_count", 32'(queue_count), DEPTH);
    end
    consume = 1'b1; tick(); consume = 1'b0;
    seen_req = 1'b0; n = 0;
    while (queue_count != DEPTH && n < 30) begin
      seen_req |= mem_request;
      tick(); n++;
    end
    chk("refill_req_seen", 32'(seen_req), 32'd1);
    chk("refill_count", 32'(queue_count), DEPTH);

    // Redirect outside WAIT: first new opcode valid 9 cycles later.
    redirect = 1'b1; redirect_target = 32'h0000_0200; fill_exp(32'h0000_0200);
    tick(); redirect = 1'b0;
    chk("redir_valid_r1", 32'(opcode_valid), 32'd0);
    chk("redir_req_r1", 32'(mem_request), 32'd1);
    chk("redir_addr_r1", mem_addr, 32'h0000_0200);
    for (int k = 1; k <= 9; k++) begin
      chk("redir_valid_cycle", 32'(opcode_valid), 32'(k == 9));
      if (k < 9) tick();
    end
    chk("redir_opcode_pc", opcode_pc, 32'h0000_0200);
    chk("redir_opcode", opcode, word_at(32'h0000_0200));

    // Reset mid-word with busy high; then 3 busy cycles per byte -> 5 cycles/byte.
    busy_mode = 2;
    n = 0;
    while (!mem_busy && n < 20) begin tick(); n++; end
    chk("busy_seen", 32'(mem_busy), 32'd1);
    reset = 1'b1; fill_exp(RESET_PC);
    tick();
    chk("rst2_req", 32'(mem_request), 32'd0);
    chk("rst2_addr", mem_addr, RESET_PC);
    chk("rst2_valid", 32'(opcode_valid), 32'd0);
    chk("rst2_count", 32'(queue_count), 32'd0);
    chk("rst2_opcode", opcode, 32'd0);
    chk("rst2_opcode_pc", opcode_pc, 32'd0);
    tick(); tick(); tick();
    reset = 1'b0;
    for (int k = 0; k <= 21; k++) begin
      if (k == 0) chk("busy_restart_addr", mem_addr, RESET_PC);
      chk("busy_valid_cycle", 32'(opcode_valid), 32'(k == 21));
      if (k < 21) tick();
    end
    chk("busy_opcode", opcode, 32'h0001_0203);
    busy_mode = 0;

    // Redirect while in WAIT with two entries queued.
    n = 0;
    while (!(queue_count == 2 && mem_request) && n < 100) begin tick(); n++; end
    chk("pre_wait_count", 32'(queue_count), 32'd2);
    tick();
    redirect = 1'b1; redirect_target = 32'h0000_0102; fill_exp(32'h0000_0102);
    tick(); redirect = 1'b0;
    chk("wait_redir_count", 32'(queue_count), 32'd0);
    chk("wait_redir_valid", 32'(opcode_valid), 32'd0);
    chk("drain_no_req", 32'(mem_request), 32'd0);
    tick();
    chk("drain_then_req", 32'(mem_request), 32'd1);
    chk("drain_then_addr", mem_addr, 32'h0000_0100);
    consume = 1'b1;
    repeat (30) tick();
    consume = 1'b0;

    // Redirect and consume together while a push completes.
    n = 0;
    while (!(queue_count >= 1 && !mem_request && mem_addr[1:0] == 2'd3) && n < 100) begin
      tick(); n++;
    end
    chk("push_cycle_found", 32'(mem_addr[1:0]), 32'd3);
    redirect = 1'b1; consume = 1'b1; redirect_target = 32'h0000_0400; fill_exp(32'h0000_0400);
    tick(); redirect = 1'b0; consume = 1'b0;
    chk("rc_count", 32'(queue_count), 32'd0);
    chk("rc_valid", 32'(opcode_valid), 32'd0);
    consume = 1'b1;
    repeat (40) tick();

    // Address wrap, then random busy/consume/redirect traffic.
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFA; fill_exp(32'hFFFF_FFFA);
    tick(); redirect = 1'b0;
    busy_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      consume = 1'($urandom_range(0, 1));
      if (c > 200 && $urandom_range(0, 99) == 0) begin
        redirect = 1'b1;
        redirect_target = $urandom();
        fill_exp(redirect_target);
      end else begin
        redirect = 1'b0;
      end
      tick();
    end
    redirect = 1'b0; consume = 1'b0; busy_mode = 0;
    tick(); tick();
    chk("pops_enough", 32'(n_pops > 100), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
